// File: rtl/fifo_drain_packer_pkg.sv
// Shared helpers for the FIFO drain packer: lane-counter sizing and keep-mask generation.
package fifo_drain_packer_pkg;

    function automatic int unsigned lane_cnt_width(input int unsigned lanes);
        return $clog2(lanes + 1);
    endfunction

    // Bit `lane` of the keep mask for a word holding `cnt` valid lanes.
    function automatic logic keep_bit(input int unsigned cnt, input int unsigned lane);
        return lane < cnt;
    endfunction

endpackage

// File: rtl/fifo_drain_packer_pack_out_reg.sv
// Single-entry valid/ready output register with load/hold/accept.
module pack_out_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned KEEP_W = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [KEEP_W-1:0] i_keep,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [KEEP_W-1:0] o_keep,
    output logic              o_free
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [KEEP_W-1:0] r_keep;

    // Callers only assert i_load when o_free is high.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/fifo_drain_packer.sv
// Pops entries from a 1-cycle-latency FIFO and packs LANES of them into one wide stream word.
module fifo_drain_packer
    import fifo_drain_packer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = lane_cnt_width(LANES)
) (
    input  logic                   pk_clk,
    input  logic                   pk_reset,
    input  logic                   pk_fifo_empty,
    output logic                   pk_fifo_ren,
    input  logic [WIDTH-1:0]       pk_fifo_rdata,
    input  logic                   pk_flush,
    output logic                   pk_out_valid,
    input  logic                   pk_out_ready,
    output logic [WIDTH*LANES-1:0] pk_out_data,
    output logic [LANES-1:0]       pk_out_keep,
    output logic                   pk_busy
);

    localparam logic [CNT_W:0]   LanesW   = (CNT_W + 1)'(LANES);
    localparam logic [CNT_W-1:0] CntHeld  = CNT_W'(LANES);
    localparam logic [CNT_W-1:0] CntLast  = CNT_W'(LANES - 1);

    logic [CNT_W-1:0]            r_cnt;
    logic                        r_inflight;
    logic                        r_flush_pending;
    logic [LANES-1:0][WIDTH-1:0] r_lanes;

    logic [CNT_W-1:0]            w_cnt_d;
    logic                        w_flush_pending_d;
    logic [LANES-1:0][WIDTH-1:0] w_lanes_d;
    logic [LANES-1:0][WIDTH-1:0] w_full_word;
    logic [LANES-1:0][WIDTH-1:0] w_part_word;
    logic [LANES-1:0][WIDTH-1:0] w_load_data;
    logic [LANES-1:0]            w_part_keep;
    logic [LANES-1:0]            w_load_keep;
    logic                        w_load;
    logic                        w_free;
    logic                        w_land_last;
    logic                        w_held;
    logic                        w_flush_go;

    assign pk_fifo_ren = !pk_reset && !pk_fifo_empty && !r_flush_pending &&
                         (({1'b0, r_cnt} + {{CNT_W{1'b0}}, r_inflight}) < LanesW);

    assign w_land_last = r_inflight && (r_cnt == CntLast);
    assign w_held      = (r_cnt == CntHeld);
    assign w_flush_go  = r_flush_pending && !r_inflight && !w_held;

    always_comb begin
        w_full_word = r_lanes;
        if (w_land_last) begin
            w_full_word[LANES-1] = pk_fifo_rdata;
        end
        for (int unsigned i = 0; i < LANES; i++) begin
            w_part_keep[i] = keep_bit(int'(r_cnt), i);
            w_part_word[i] = w_part_keep[i] ? r_lanes[i] : '0;
        end
    end

    always_comb begin
        w_cnt_d           = r_cnt;
        w_lanes_d         = r_lanes;
        w_flush_pending_d = r_flush_pending || pk_flush;
        w_load            = 1'b0;
        w_load_data       = w_full_word;
        w_load_keep       = '1;
        if (r_inflight) begin
            if (w_land_last) begin
                if (w_free) begin
                    w_load  = 1'b1;
                    w_cnt_d = '0;
                end else begin
                    // Output blocked: park the complete word in the lane registers.
                    w_lanes_d[LANES-1] = pk_fifo_rdata;
                    w_cnt_d            = CntHeld;
                end
            end else begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    if (r_cnt == CNT_W'(i)) begin
                        w_lanes_d[i] = pk_fifo_rdata;
                    end
                end
                w_cnt_d = r_cnt + CNT_W'(1);
            end
        end else if (w_held) begin
            if (w_free) begin
                w_load  = 1'b1;
                w_cnt_d = '0;
            end
        end else if (w_flush_go) begin
            if (r_cnt == '0) begin
                w_flush_pending_d = 1'b0;
            end else if (w_free) begin
                w_load            = 1'b1;
                w_load_data       = w_part_word;
                w_load_keep       = w_part_keep;
                w_cnt_d           = '0;
                w_flush_pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge pk_clk) begin
        if (pk_reset) begin
            r_cnt           <= '0;
            r_inflight      <= 1'b0;
            r_flush_pending <= 1'b0;
            r_lanes         <= '0;
        end else begin
            r_cnt           <= w_cnt_d;
            r_inflight      <= pk_fifo_ren;
            r_flush_pending <= w_flush_pending_d;
            r_lanes         <= w_lanes_d;
        end
    end

    pack_out_reg #(
        .DATA_W(WIDTH * LANES),
        .KEEP_W(LANES)
    ) u_out_reg (
        .i_clk   (pk_clk),
        .i_reset (pk_reset),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_keep  (w_load_keep),
        .i_ready (pk_out_ready),
        .o_valid (pk_out_valid),
        .o_data  (pk_out_data),
        .o_keep  (pk_out_keep),
        .o_free  (w_free)
    );

    assign pk_busy = (r_cnt != '0) || r_inflight || r_flush_pending || pk_out_valid;

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Directed self-checking bench for fifo_drain_packer with a behavioural 1-cycle-latency FIFO.
module tb_fifo_drain_packer;

    localparam int WIDTH = 8;
    localparam int LANES = 4;

    logic                   pk_clk = 1'b0;
    logic                   pk_reset = 1'b1;
    logic                   pk_fifo_empty;
    logic                   pk_fifo_ren;
    logic [WIDTH-1:0]       pk_fifo_rdata = '0;
    logic                   pk_flush = 1'b0;
    logic                   pk_out_valid;
    logic                   pk_out_ready = 1'b1;
    logic [WIDTH*LANES-1:0] pk_out_data;
    logic [LANES-1:0]       pk_out_keep;
    logic                   pk_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural FIFO
    logic [WIDTH-1:0] mem [0:63];
    int   wr_ptr   = 0;
    int   rd_ptr   = 0;
    int   pops     = 0;
    int   ren_err  = 0;
    logic fifo_clr = 1'b0;
    logic gate     = 1'b0;
    logic gate_en  = 1'b0;

    assign pk_fifo_empty = (rd_ptr == wr_ptr) || gate;

    always #5 pk_clk = ~pk_clk;

    always @(posedge pk_clk) begin
        if (fifo_clr) begin
            rd_ptr  <= 0;
            pops    <= 0;
            ren_err <= 0;
        end else if (pk_fifo_ren) begin
            if (pk_fifo_empty) ren_err <= ren_err + 1;
            pk_fifo_rdata <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
            pops          <= pops + 1;
        end
    end

    fifo_drain_packer #(
        .WIDTH(WIDTH),
        .LANES(LANES),
        .CNT_W(3)
    ) dut (
        .pk_clk        (pk_clk),
        .pk_reset      (pk_reset),
        .pk_fifo_empty (pk_fifo_empty),
        .pk_fifo_ren   (pk_fifo_ren),
        .pk_fifo_rdata (pk_fifo_rdata),
        .pk_flush      (pk_flush),
        .pk_out_valid  (pk_out_valid),
        .pk_out_ready  (pk_out_ready),
        .pk_out_data   (pk_out_data),
        .pk_out_keep   (pk_out_keep),
        .pk_busy       (pk_busy)
    );

    // Captured output words
    logic [WIDTH*LANES-1:0] got_data [0:7];
    logic [LANES-1:0]       got_keep [0:7];
    int                     got_cyc  [0:7];
    int                     n_words;
    int                     cyc;

    task automatic push(input logic [WIDTH-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic reset_assert();
        pk_reset     = 1'b1;
        pk_flush     = 1'b0;
        pk_out_ready = 1'b1;
        gate_en      = 1'b0;
        gate         = 1'b0;
        fifo_clr     = 1'b1;
        wr_ptr       = 0;
        n_words      = 0;
        cyc          = 0;
        repeat (2) @(negedge pk_clk);
        fifo_clr = 1'b0;
    endtask

    task automatic collect(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge pk_clk);
            cyc = cyc + 1;
            if (gate_en) gate = ~gate;
            if (pk_out_valid && pk_out_ready && n_words < 8) begin
                got_data[n_words] = pk_out_data;
                got_keep[n_words] = pk_out_keep;
                got_cyc[n_words]  = cyc;
                n_words = n_words + 1;
            end
        end
    endtask

    task automatic test_reset_and_stream();
        int gap;
        reset_assert();
        for (int i = 1; i <= 8; i++) push(8'(i));
        @(negedge pk_clk);
        #1;
        n_tests++;
        if (pk_out_valid !== 1'b0 || pk_out_keep !== 4'h0 || pk_out_data !== 32'h0 ||
            pk_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b keep=%h data=%h busy=%b, want 0 0 0 0",
                     pk_out_valid, pk_out_keep, pk_out_data, pk_busy);
        end
        n_tests++;
        if (pk_fifo_ren !== 1'b0) begin
            n_fail++;
            $display("FAIL ren_in_reset: ren=%b want 0", pk_fifo_ren);
        end
        pk_reset = 1'b0;
        #1;
        n_tests++;
        if (pk_fifo_ren !== 1'b1) begin
            n_fail++;
            $display("FAIL first_ren: ren=%b want 1", pk_fifo_ren);
        end
        collect(30);
        n_tests++;
        if (n_words !== 2) begin
            n_fail++;
            $display("FAIL stream_count: got %0d words want 2", n_words);
        end else begin
            n_tests++;
            if (got_data[0] !== 32'h04030201 || got_keep[0] !== 4'hF) begin
                n_fail++;
                $display("FAIL stream_w0: data=%h keep=%h want 04030201 f",
                         got_data[0], got_keep[0]);
            end
            n_tests++;
            if (got_data[1] !== 32'h08070605 || got_keep[1] !== 4'hF) begin
                n_fail++;
                $display("FAIL stream_w1: data=%h keep=%h want 08070605 f",
                         got_data[1], got_keep[1]);
            end
            gap = got_cyc[1] - got_cyc[0];
            n_tests++;
            if (gap !== 5) begin
                n_fail++;
                $display("FAIL stream_gap: got %0d cycles want 5", gap);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH*LANES-1:0] held;
        logic                   seen;
        int                     unstable;
        reset_assert();
        for (int i = 1; i <= 12; i++) push(8'(i));
        pk_out_ready = 1'b0;
        @(negedge pk_clk);
        pk_reset = 1'b0;
        seen     = 1'b0;
        unstable = 0;
        held     = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge pk_clk);
            if (pk_out_valid) begin
                if (!seen) begin
                    held = pk_out_data;
                    seen = 1'b1;
                end else if (pk_out_data !== held || pk_out_keep !== 4'hF) begin
                    unstable++;
                end
            end
        end
        n_tests++;
        if (seen !== 1'b1 || held !== 32'h04030201 || unstable !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: seen=%b data=%h unstable=%0d want 1 04030201 0",
                     seen, held, unstable);
        end
        n_tests++;
        if (pops !== 8) begin
            n_fail++;
            $display("FAIL bp_pops: got %0d pops want 8", pops);
        end
        pk_out_ready = 1'b1;
        #1;
        if (pk_out_valid) begin
            got_data[0] = pk_out_data;
            got_keep[0] = pk_out_keep;
            n_words = 1;
        end
        collect(30);
        n_tests++;
        if (n_words !== 3 || got_data[0] !== 32'h04030201 || got_data[1] !== 32'h08070605 ||
            got_data[2] !== 32'h0C0B0A09) begin
            n_fail++;
            $display("FAIL bp_order: n=%0d w0=%h w1=%h w2=%h want 3 04030201 08070605 0c0b0a09",
                     n_words, got_data[0], got_data[1], got_data[2]);
        end
    endtask

    task automatic test_flush_partial();
        reset_assert();
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        @(negedge pk_clk);
        pk_reset = 1'b0;
        collect(6);
        n_tests++;
        if (n_words !== 0) begin
            n_fail++;
            $display("FAIL flush_early: got %0d words before flush want 0", n_words);
        end
        pk_flush = 1'b1;
        @(negedge pk_clk);
        pk_flush = 1'b0;
        collect(10);
        n_tests++;
        if (n_words !== 1 || got_data[0] !== 32'h00A3A2A1 || got_keep[0] !== 4'h7) begin
            n_fail++;
            $display("FAIL flush_word: n=%0d data=%h keep=%h want 1 00a3a2a1 7",
                     n_words, got_data[0], got_keep[0]);
        end
        n_tests++;
        if (pk_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: busy=%b want 0", pk_busy);
        end
    endtask

    task automatic test_flush_empty();
        reset_assert();
        @(negedge pk_clk);
        pk_reset = 1'b0;
        @(negedge pk_clk);
        pk_flush = 1'b1;
        @(negedge pk_clk);
        pk_flush = 1'b0;
        n_tests++;
        if (pk_busy !== 1'b1 || pk_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush0_pending: busy=%b valid=%b want 1 0", pk_busy, pk_out_valid);
        end
        @(negedge pk_clk);
        n_tests++;
        if (pk_busy !== 1'b0 || pk_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush0_clear: busy=%b valid=%b want 0 0", pk_busy, pk_out_valid);
        end
    endtask

    task automatic test_empty_toggle();
        reset_assert();
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
        @(negedge pk_clk);
        pk_reset = 1'b0;
        gate_en  = 1'b1;
        collect(60);
        gate_en = 1'b0;
        gate    = 1'b0;
        n_tests++;
        if (ren_err !== 0) begin
            n_fail++;
            $display("FAIL toggle_ren_empty: %0d pops while empty want 0", ren_err);
        end
        n_tests++;
        if (n_words !== 2 || got_data[0] !== 32'h33323130 || got_data[1] !== 32'h37363534 ||
            got_keep[0] !== 4'hF || got_keep[1] !== 4'hF) begin
            n_fail++;
            $display("FAIL toggle_words: n=%0d w0=%h w1=%h want 2 33323130 37363534",
                     n_words, got_data[0], got_data[1]);
        end
    endtask

    task automatic test_reset_midword();
        reset_assert();
        push(8'h11);
        push(8'h12);
        push(8'h13);
        @(negedge pk_clk);
        pk_reset = 1'b0;
        repeat (3) @(negedge pk_clk);
        n_tests++;
        if (pk_busy !== 1'b1 || pops !== 3) begin
            n_fail++;
            $display("FAIL midword_setup: busy=%b pops=%0d want 1 3", pk_busy, pops);
        end
        pk_reset = 1'b1;
        @(negedge pk_clk);
        pk_reset = 1'b0;
        #1;
        n_tests++;
        if (pk_out_valid !== 1'b0 || pk_out_keep !== 4'h0 || pk_out_data !== 32'h0 ||
            pk_busy !== 1'b0 || pk_fifo_ren !== 1'b0) begin
            n_fail++;
            $display("FAIL midword_cleared: valid=%b keep=%h data=%h busy=%b ren=%b want 0s",
                     pk_out_valid, pk_out_keep, pk_out_data, pk_busy, pk_fifo_ren);
        end
        for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
        collect(15);
        n_tests++;
        if (n_words !== 1 || got_data[0] !== 32'h24232221 || got_keep[0] !== 4'hF) begin
            n_fail++;
            $display("FAIL midword_clean: n=%0d data=%h keep=%h want 1 24232221 f",
                     n_words, got_data[0], got_keep[0]);
        end
    endtask

    initial begin
        test_reset_and_stream();
        test_backpressure();
        test_flush_partial();
        test_flush_empty();
        test_empty_toggle();
        test_reset_midword();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
